elevator_scheduler: RTL and testbench

ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

---
 rtl/elevator_scheduler.sv | 212 +++++++++++++++++++++
 tb/tb_elevator_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_scheduler.sv
// -----------------------------------------------------------------------------
// elevator_scheduler
//   Single-car elevator controller. Floor calls latch into a pending mask. The
//   car keeps moving in its current direction while calls remain ahead of it,
//   and reverses only when nothing is left ahead (collective/SCAN behaviour).
//   Travel and door dwell are timed in strobes of an external tick.
//
// Ports
//   clk            system clock, all state changes on the rising edge
//   rst            asynchronous active-low reset
//   tick           one-cycle timebase strobe; timers advance only when high
//   req            floor call buttons, one bit per floor, level-sensitive
//   estop          emergency stop, level-sensitive
//   destination    registered pending-request mask
//   sim_state      registered state code: IDLE=00 MOVING=01 DOORS=10 HALT=11
//   current_floor  registered car position
//   dir_up         registered travel direction (1 = up, 0 = down)
// -----------------------------------------------------------------------------
module elevator_scheduler #(
   parameter  int FLOORS     = 8,
   parameter  int MOVE_TICKS = 4,
   parameter  int DOOR_TICKS = 3,
   localparam int FW         = (FLOORS > 1) ? $clog2(FLOORS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick,
   input  logic [FLOORS-1:0] req,
   input  logic              estop,
   output logic [FLOORS-1:0] destination,
   output logic [1:0]        sim_state,
   output logic [FW-1:0]     current_floor,
   output logic              dir_up
);

   localparam int MCW = (MOVE_TICKS > 1) ? $clog2(MOVE_TICKS) : 1;
   localparam int DCW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;

   localparam logic [MCW-1:0] MOVE_LAST  = MCW'(MOVE_TICKS - 1);
   localparam logic [MCW-1:0] MOVE_ONE   = MCW'(1);
   localparam logic [MCW-1:0] MOVE_ZERO  = MCW'(0);
   localparam logic [DCW-1:0] DOOR_LAST  = DCW'(DOOR_TICKS - 1);
   localparam logic [DCW-1:0] DOOR_ONE   = DCW'(1);
   localparam logic [DCW-1:0] DOOR_ZERO  = DCW'(0);
   localparam logic [FW-1:0]  TOP_FLOOR  = FW'(FLOORS - 1);
   localparam logic [FW-1:0]  ONE_FLOOR  = FW'(1);
   localparam logic [FW-1:0]  BASE_FLOOR = FW'(0);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_MOVING = 2'b01,
      ST_DOORS  = 2'b10,
      ST_HALT   = 2'b11
   } state_t;

   state_t            state_r;
   logic [FLOORS-1:0] pending_r;
   logic [FW-1:0]     floor_r;
   logic              dir_up_r;
   logic [MCW-1:0]    move_cnt_r;
   logic [DCW-1:0]    door_cnt_r;

   logic [FW-1:0]     step_floor_s;
   logic [FLOORS-1:0] here_bit_s;
   logic [FLOORS-1:0] arrive_bit_s;
   logic [FLOORS-1:0] req_eff_s;
   logic [FLOORS-1:0] clr_s;
   logic [FLOORS-1:0] pending_nxt_s;
   logic              here_pend_s;
   logic              ahead_s;
   logic              behind_s;
   logic              arr_pend_s;
   logic              arr_ahead_s;
   logic              move_done_s;
   logic              door_done_s;

   // One-hot mask of a single floor.
   function automatic logic [FLOORS-1:0] floor_bit(input logic [FW-1:0] f);
      logic [FLOORS-1:0] m;
      for (int i = 0; i < FLOORS; i++) begin
         m[i] = (i == int'(f));
      end
      return m;
   endfunction

   // Floors strictly above f (up=1) or strictly below f (up=0).
   function automatic logic [FLOORS-1:0] side_mask(input logic [FW-1:0] f, input logic up);
      logic [FLOORS-1:0] m;
      for (int i = 0; i < FLOORS; i++) begin
         m[i] = up ? (i > int'(f)) : (i < int'(f));
      end
      return m;
   endfunction

   // Scheduling decode: neighbour floor, request lookups, door-entry clear.
   always_comb begin
      step_floor_s = floor_r;
      if (dir_up_r) begin
         if (floor_r == TOP_FLOOR) step_floor_s = floor_r;
         else                      step_floor_s = floor_r + ONE_FLOOR;
      end else begin
         if (floor_r == BASE_FLOOR) step_floor_s = floor_r;
         else                       step_floor_s = floor_r - ONE_FLOOR;
      end

      here_bit_s   = floor_bit(floor_r);
      arrive_bit_s = floor_bit(step_floor_s);
      here_pend_s  = |(pending_r & here_bit_s);
      ahead_s      = |(pending_r & side_mask(floor_r, dir_up_r));
      behind_s     = |(pending_r & side_mask(floor_r, ~dir_up_r));
      arr_pend_s   = |(pending_r & arrive_bit_s);
      arr_ahead_s  = |(pending_r & side_mask(step_floor_s, dir_up_r));
      move_done_s  = tick && (move_cnt_r == MOVE_LAST);
      door_done_s  = tick && (door_cnt_r == DOOR_LAST);

      // A call for the floor whose doors are already open is already served.
      if (state_r == ST_DOORS) req_eff_s = req & ~here_bit_s;
      else                     req_eff_s = req;

      // Clear is the floor being entered with doors opening; estop pre-empts it.
      clr_s = {FLOORS{1'b0}};
      if (!estop) begin
         case (state_r)
            ST_IDLE: begin
               if (here_pend_s) clr_s = here_bit_s;
               else             clr_s = {FLOORS{1'b0}};
            end
            ST_MOVING: begin
               if (move_done_s && arr_pend_s) clr_s = arrive_bit_s;
               else                           clr_s = {FLOORS{1'b0}};
            end
            default: clr_s = {FLOORS{1'b0}};
         endcase
      end else begin
         clr_s = {FLOORS{1'b0}};
      end

      pending_nxt_s = (pending_r | req_eff_s) & ~clr_s;
   end

   // Car FSM, position, direction, timers and pending-request mask.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= ST_IDLE;
         pending_r  <= {FLOORS{1'b0}};
         floor_r    <= BASE_FLOOR;
         dir_up_r   <= 1'b1;
         move_cnt_r <= MOVE_ZERO;
         door_cnt_r <= DOOR_ZERO;
      end else begin
         pending_r <= pending_nxt_s;
         if (estop) begin
            // Position and direction hold; any partial travel is discarded.
            state_r    <= ST_HALT;
            move_cnt_r <= MOVE_ZERO;
            door_cnt_r <= DOOR_ZERO;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  if (here_pend_s) begin
                     state_r <= ST_DOORS;
                  end else if (ahead_s) begin
                     state_r <= ST_MOVING;
                  end else if (behind_s) begin
                     dir_up_r <= ~dir_up_r;
                     state_r  <= ST_MOVING;
                  end else begin
                     state_r <= ST_IDLE;
                  end
               end
               ST_MOVING: begin
                  if (move_done_s) begin
                     floor_r    <= step_floor_s;
                     move_cnt_r <= MOVE_ZERO;
                     if (arr_pend_s)       state_r <= ST_DOORS;
                     else if (arr_ahead_s) state_r <= ST_MOVING;
                     else                  state_r <= ST_IDLE;
                  end else if (tick) begin
                     move_cnt_r <= move_cnt_r + MOVE_ONE;
                  end else begin
                     move_cnt_r <= move_cnt_r;
                  end
               end
               ST_DOORS: begin
                  if (door_done_s) begin
                     door_cnt_r <= DOOR_ZERO;
                     state_r    <= ST_IDLE;
                  end else if (tick) begin
                     door_cnt_r <= door_cnt_r + DOOR_ONE;
                  end else begin
                     door_cnt_r <= door_cnt_r;
                  end
               end
               ST_HALT: begin
                  state_r <= ST_IDLE;
               end
               default: begin
                  state_r    <= ST_IDLE;
                  move_cnt_r <= MOVE_ZERO;
                  door_cnt_r <= DOOR_ZERO;
               end
            endcase
         end
      end
   end

   assign destination   = pending_r;
   assign sim_state     = state_r;
   assign current_floor = floor_r;
   assign dir_up        = dir_up_r;

endmodule

// File: tb/tb_elevator_scheduler.sv
// -----------------------------------------------------------------------------
// tb_elevator_scheduler
//   Directed bench for elevator_scheduler with default parameters. Each step
//   drives stimulus, queues the outputs it should produce, advances the clock
//   and then drains the queue against the live outputs.
// -----------------------------------------------------------------------------
module tb_elevator_scheduler;

   localparam logic [7:0] S_IDLE  = 8'h00;
   localparam logic [7:0] S_MOV   = 8'h01;
   localparam logic [7:0] S_DOORS = 8'h02;
   localparam logic [7:0] S_HALT  = 8'h03;

   localparam logic [2:0] SEL_STATE = 3'd0;
   localparam logic [2:0] SEL_DEST  = 3'd1;
   localparam logic [2:0] SEL_FLOOR = 3'd2;
   localparam logic [2:0] SEL_DIR   = 3'd3;
   localparam logic [2:0] SEL_LAT   = 3'd4;

   logic       clk;
   logic       rst;
   logic       tick;
   logic [7:0] req;
   logic       estop;
   logic [7:0] destination;
   logic [1:0] sim_state;
   logic [2:0] current_floor;
   logic       dir_up;

   typedef struct {
      logic [2:0] sel;
      logic [7:0] exp;
      string      tag;
   } exp_t;

   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;
   int   lat_n  = 0;

   elevator_scheduler dut (
      .clk           (clk),
      .rst           (rst),
      .tick          (tick),
      .req           (req),
      .estop         (estop),
      .destination   (destination),
      .sim_state     (sim_state),
      .current_floor (current_floor),
      .dir_up        (dir_up)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [2:0] sel, input logic [7:0] exp, input string tag);
      exp_t e;
      e.sel = sel;
      e.exp = exp;
      e.tag = tag;
      sb_q.push_back(e);
   endtask

   task automatic push_st(input string tag, input logic [7:0] st, input logic [7:0] fl,
                          input logic [7:0] dst);
      push(SEL_STATE, st,  {tag, "_state"});
      push(SEL_FLOOR, fl,  {tag, "_floor"});
      push(SEL_DEST,  dst, {tag, "_dest"});
   endtask

   task automatic drain();
      exp_t       e;
      logic [7:0] obs;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         case (e.sel)
            SEL_STATE: obs = {6'd0, sim_state};
            SEL_DEST:  obs = destination;
            SEL_FLOOR: obs = {5'd0, current_floor};
            SEL_DIR:   obs = {7'd0, dir_up};
            default:   obs = lat_n[7:0];
         endcase
         checks++;
         assert (obs === e.exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.exp);
         end
      end
   endtask

   // Steps until current_floor equals target; lat_n = edges taken, or max+1 on timeout.
   task automatic wait_floor(input logic [2:0] target, input int max_cyc);
      lat_n = max_cyc + 1;
      for (int i = 1; i <= max_cyc; i++) begin
         step();
         if (current_floor == target) begin
            lat_n = i;
            break;
         end
      end
   endtask

   initial begin
      rst   = 1'b0;
      tick  = 1'b1;
      req   = 8'h00;
      estop = 1'b0;
      #2;
      push_st("rst_hold", S_IDLE, 8'd0, 8'h00);
      push(SEL_DIR, 8'd1, "rst_hold_dir");
      step(); step();
      drain();
      rst = 1'b1;
      push_st("rst_release", S_IDLE, 8'd0, 8'h00);
      step(); drain();

      // Single call to floor 3 from floor 0.
      req = 8'h08;
      push_st("a_latch", S_IDLE, 8'd0, 8'h08);
      step(); req = 8'h00; drain();
      push(SEL_STATE, S_MOV, "a_moving");
      push(SEL_DIR, 8'd1, "a_dir");
      step(); drain();
      push(SEL_LAT, 8'd12, "a_travel_ticks");
      push_st("a_arrive", S_DOORS, 8'd3, 8'h00);
      wait_floor(3'd3, 40); drain();
      push(SEL_STATE, S_DOORS, "a_doors_hold");
      step(); step(); drain();
      push_st("a_closed", S_IDLE, 8'd3, 8'h00);
      step(); drain();

      // Floor 3 going up with calls at 7 and 0; tick frozen for a while.
      tick = 1'b0;
      req  = 8'h80;
      step();
      req  = 8'h01;
      push_st("b_depart_notick", S_MOV, 8'd3, 8'h81);
      step(); req = 8'h00; drain();
      push_st("b_frozen", S_MOV, 8'd3, 8'h81);
      for (int i = 0; i < 6; i++) step();
      drain();
      tick = 1'b1;
      push(SEL_LAT, 8'd16, "b_up_ticks");
      push_st("b_top", S_DOORS, 8'd7, 8'h01);
      wait_floor(3'd7, 40); drain();
      push_st("b_top_closed", S_IDLE, 8'd7, 8'h01);
      push(SEL_DIR, 8'd1, "b_top_dir_hold");
      step(); step(); step(); drain();
      push(SEL_STATE, S_MOV, "b_reverse_state");
      push(SEL_DIR, 8'd0, "b_reverse_dir");
      step(); drain();
      push(SEL_LAT, 8'd28, "b_down_ticks");
      push_st("b_bottom", S_DOORS, 8'd0, 8'h00);
      wait_floor(3'd0, 60); drain();
      push_st("b_done", S_IDLE, 8'd0, 8'h00);
      push(SEL_DIR, 8'd0, "b_done_dir");
      step(); step(); step(); drain();

      // Emergency stop mid-travel between floors 1 and 2, call pending at 4.
      req = 8'h10;
      step(); req = 8'h00;
      push(SEL_STATE, S_MOV, "d_depart");
      push(SEL_DIR, 8'd1, "d_dir_forced_up");
      step(); drain();
      push(SEL_LAT, 8'd4, "d_first_floor");
      wait_floor(3'd1, 20); drain();
      step(); step();
      estop = 1'b1;
      push_st("d_halt", S_HALT, 8'd1, 8'h10);
      step(); drain();
      push_st("d_halt_hold", S_HALT, 8'd1, 8'h10);
      step(); drain();
      estop = 1'b0;
      push_st("d_resume_idle", S_IDLE, 8'd1, 8'h10);
      step(); drain();
      push(SEL_STATE, S_MOV, "d_resume_move");
      step(); drain();
      push(SEL_LAT, 8'd4, "d_full_ticks_f2");
      wait_floor(3'd2, 20); drain();
      push(SEL_LAT, 8'd4, "d_full_ticks_f3");
      wait_floor(3'd3, 20); drain();
      push_st("d_pre_arrive", S_MOV, 8'd3, 8'h10);
      step(); step(); step(); drain();

      // Call at 4 raised in the very cycle the car arrives at 4.
      req = 8'h10;
      push_st("e_arrive_clr", S_DOORS, 8'd4, 8'h00);
      step(); drain();
      req = 8'h14;
      push_st("e_doors_mask", S_DOORS, 8'd4, 8'h04);
      step(); req = 8'h00; drain();
      push_st("e_closed", S_IDLE, 8'd4, 8'h04);
      step(); step(); drain();
      push(SEL_STATE, S_MOV, "e_down_state");
      push(SEL_DIR, 8'd0, "e_down_dir");
      step(); drain();
      push(SEL_LAT, 8'd8, "e_down_ticks");
      push_st("e_floor2", S_DOORS, 8'd2, 8'h00);
      wait_floor(3'd2, 20); drain();
      step(); step(); step();

      // Doors opened in place when idle at the called floor; held call ignored.
      req = 8'h04;
      push_st("c_latch", S_IDLE, 8'd2, 8'h04);
      step(); drain();
      push_st("c_open", S_DOORS, 8'd2, 8'h00);
      step(); drain();
      push_st("c_held_ignored", S_DOORS, 8'd2, 8'h00);
      step(); step(); drain();
      req = 8'h00;
      push_st("c_closed", S_IDLE, 8'd2, 8'h00);
      step(); drain();

      // Reset asserted while moving from floor 2.
      req = 8'h80;
      step(); req = 8'h00;
      step(); step();
      push_st("r_pre_reset", S_MOV, 8'd2, 8'h80);
      drain();
      rst = 1'b0;
      #2;
      push_st("r_async", S_IDLE, 8'd0, 8'h00);
      push(SEL_DIR, 8'd1, "r_async_dir");
      drain();
      step(); step();
      rst = 1'b1;
      push_st("r_restart", S_IDLE, 8'd0, 8'h00);
      step(); step(); step(); drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
